// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator keypad-entry path.
//  - state_e : entry FSM state encoding (also exported on the debug port)
//  - OP_*    : operator codes understood by the ALU
//  - cnt_w() : width of a digit counter able to hold 0..digits
package calc_pkg;

  typedef enum logic [2:0] {
    ST_N1   = 3'd0,
    ST_OP   = 3'd1,
    ST_N2   = 3'd2,
    ST_EXEC = 3'd3,
    ST_RES  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam int DIGITS_DEF = 4;
  localparam int OP_W_DEF   = 2;

  function automatic int cnt_w(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/digit_entry_reg.sv
// digit_entry_reg: one operand register built from nibble key digits.
//  clk_i/rst_ni : clock, async active-low reset
//  clr_i        : zero value and digit count (highest priority)
//  ld_i         : load ld_val_i with digit count ld_cnt_i
//  shift_i      : shift digit_i in from the right while count < DIGITS
//  val_o        : operand value (4*DIGITS bits)
module digit_entry_reg
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        ld_i,
  input  logic                        shift_i,
  input  logic [4*DIGITS-1:0]         ld_val_i,
  input  logic [cnt_w(DIGITS)-1:0]    ld_cnt_i,
  input  logic [3:0]                  digit_i,
  output logic [4*DIGITS-1:0]         val_o
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = cnt_w(DIGITS);

  logic [W-1:0]  val_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      val_q <= '0;
      cnt_q <= '0;
    end else if (ld_i) begin
      val_q <= ld_val_i;
      cnt_q <= ld_cnt_i;
    end else if (shift_i && (cnt_q < CW'(DIGITS))) begin
      // shift form keeps DIGITS=1 legal (no negative part-select)
      val_q <= (val_q << 4) | W'(digit_i);
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad-entry controller between key decoder and ALU.
//  Builds operands from digit keys, latches the operator, runs the ALU via
//  alu_start/alu_done, supports chained operators and an error state.
//  Key side : key_valid/key_ready, is_num/is_op/is_eq/is_clr, num_val, op_val
//  ALU side : alu_start, alu_done, alu_result, alu_err
//  Display  : num1, num2, operation, state (debug), error
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic                is_num,
  input  logic                is_op,
  input  logic                is_eq,
  input  logic                is_clr,
  input  logic [3:0]          num_val,
  input  logic [OP_W-1:0]     op_val,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [4*DIGITS-1:0] alu_result,
  input  logic                alu_err,
  output logic [4*DIGITS-1:0] num1,
  output logic [4*DIGITS-1:0] num2,
  output logic [OP_W-1:0]     operation,
  output logic [2:0]          state,
  output logic                error
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = cnt_w(DIGITS);

  state_e          state_q, state_d, tgt_q, tgt_d;
  logic [OP_W-1:0] op_q, op_d, pend_q, pend_d;
  logic            start_q, start_d, rdy_q, err_q;
  logic            acc, k_clr, k_eq, k_op, k_num;
  logic            clr1, ld1, sh1, ld1_res, clr2, ld2, sh2;
  logic [W-1:0]    digit_w, ld1_val;
  logic [CW-1:0]   ld1_cnt;

  // one key kind per event, clr > eq > op > num
  assign acc   = key_valid & rdy_q;
  assign k_clr = acc & is_clr;
  assign k_eq  = acc & ~is_clr & is_eq;
  assign k_op  = acc & ~is_clr & ~is_eq & is_op;
  assign k_num = acc & ~is_clr & ~is_eq & ~is_op & is_num;

  assign digit_w = W'(num_val);
  assign ld1_val = ld1_res ? alu_result : digit_w;
  // a result fills num1, so further digits would be dropped anyway
  assign ld1_cnt = ld1_res ? CW'(DIGITS) : CW'(1);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    op_d    = op_q;
    pend_d  = pend_q;
    start_d = 1'b0;
    clr1 = 1'b0; ld1 = 1'b0; sh1 = 1'b0; ld1_res = 1'b0;
    clr2 = 1'b0; ld2 = 1'b0; sh2 = 1'b0;
    case (state_q)
      ST_N1: begin
        if (k_num) sh1 = 1'b1;
        else if (k_op) begin op_d = op_val; state_d = ST_OP; end
      end
      ST_OP: begin
        if (k_op) op_d = op_val;
        else if (k_num) begin ld2 = 1'b1; state_d = ST_N2; end
      end
      ST_N2: begin
        if (k_num) sh2 = 1'b1;
        else if (k_eq) begin
          start_d = 1'b1; tgt_d = ST_RES; state_d = ST_EXEC;
        end else if (k_op) begin
          // chained operator: applied once the current result is back
          start_d = 1'b1; tgt_d = ST_OP; pend_d = op_val; state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (alu_done) begin
          if (alu_err) state_d = ST_ERR;
          else begin
            ld1 = 1'b1; ld1_res = 1'b1; clr2 = 1'b1;
            state_d = tgt_q;
            if (tgt_q == ST_OP) op_d = pend_q;
          end
        end
      end
      ST_RES: begin
        if (k_num) begin ld1 = 1'b1; state_d = ST_N1; end
        else if (k_op) begin op_d = op_val; state_d = ST_OP; end
      end
      ST_ERR: ;
      default: state_d = ST_N1;
    endcase
    // key_ready is low in EXEC, so clr can never cut an ALU operation short
    if (k_clr) begin
      state_d = ST_N1; tgt_d = ST_N1; op_d = '0; pend_d = '0;
      clr1 = 1'b1; clr2 = 1'b1; ld1 = 1'b0; sh1 = 1'b0; ld2 = 1'b0; sh2 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_N1;
      tgt_q   <= ST_N1;
      op_q    <= OP_W'(OP_ADD);
      pend_q  <= '0;
      start_q <= 1'b0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      rdy_q   <= (state_d != ST_EXEC);
      err_q   <= (state_d == ST_ERR);
    end
  end

  digit_entry_reg #(.DIGITS(DIGITS)) u_num1 (
    .clk_i(clk), .rst_ni(reset), .clr_i(clr1), .ld_i(ld1), .shift_i(sh1),
    .ld_val_i(ld1_val), .ld_cnt_i(ld1_cnt), .digit_i(num_val), .val_o(num1)
  );

  digit_entry_reg #(.DIGITS(DIGITS)) u_num2 (
    .clk_i(clk), .rst_ni(reset), .clr_i(clr2), .ld_i(ld2), .shift_i(sh2),
    .ld_val_i(digit_w), .ld_cnt_i(CW'(1)), .digit_i(num_val), .val_o(num2)
  );

  assign key_ready = rdy_q;
  assign alu_start = start_q;
  assign operation = op_q;
  assign state     = state_q;
  assign error     = err_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
module tb_calc_entry_ctrl;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid, is_num, is_op, is_eq, is_clr;
  logic [3:0]  num_val;
  logic [1:0]  op_val;
  logic        alu_done, alu_err;
  logic [15:0] alu_result;
  logic        key_ready, alu_start, error;
  logic [15:0] num1, num2;
  logic [1:0]  operation;
  logic [2:0]  state;

  int checks = 0;
  int fails  = 0;
  int starts = 0;

  calc_entry_ctrl #(.DIGITS(4), .OP_W(2)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
    .is_num(is_num), .is_op(is_op), .is_eq(is_eq), .is_clr(is_clr),
    .num_val(num_val), .op_val(op_val), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .num1(num1), .num2(num2), .operation(operation), .state(state), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (alu_start === 1'b1) starts++;

  typedef struct {
    logic n, o, e, c;
    logic [3:0]  nv;
    logic [1:0]  ov;
    logic [15:0] e1, e2;
    logic [1:0]  eop;
    logic [2:0]  est;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(input logic n, o, e, c, input logic [3:0] nv,
                              input logic [1:0] ov, input logic [15:0] e1, e2,
                              input logic [1:0] eop, input logic [2:0] est);
    vec_t v;
    v.n = n; v.o = o; v.e = e; v.c = c; v.nv = nv; v.ov = ov;
    v.e1 = e1; v.e2 = e2; v.eop = eop; v.est = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {key_ready, error, num1, num2, operation, state}
  task automatic chk_st(input string name, input logic [15:0] e1, e2,
                        input logic [1:0] eop, input logic [2:0] est, input logic eerr);
    chk(name, {key_ready, error, num1, num2, operation, state},
              {1'b1, eerr, e1, e2, eop, est});
  endtask

  // entered on a negedge; returns on the next negedge with the key applied
  task automatic press(input logic n, o, e, c, input logic [3:0] nv, input logic [1:0] ov);
    key_valid = 1'b1; is_num = n; is_op = o; is_eq = e; is_clr = c;
    num_val = nv; op_val = ov;
    @(negedge clk);
    key_valid = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0; is_clr = 1'b0;
  endtask

  task automatic num(input logic [3:0] d); press(1'b0 | 1'b1, 1'b0, 1'b0, 1'b0, d, 2'd0); endtask
  task automatic op(input logic [1:0] o);  press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, o); endtask
  task automatic eq();                     press(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0); endtask
  task automatic clr();                    press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0); endtask

  // called on the first EXEC negedge; ALU answers lat cycles after start
  task automatic run_alu(input string name, input int lat, input logic [15:0] res,
                         input logic err);
    int low = 0;
    int st  = 0;
    for (int i = 0; i < lat; i++) begin
      if (i > 0) @(negedge clk);
      if (key_ready === 1'b0) low++;
      if (alu_start === 1'b1) st++;
    end
    alu_done = 1'b1; alu_result = res; alu_err = err;
    @(negedge clk);
    alu_done = 1'b0; alu_err = 1'b0; alu_result = 16'h0;
    chk({name, "_busy"}, 64'(low), 64'(lat));
    chk({name, "_start"}, 64'(st), 64'd1);
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    is_clr = 1'b0; num_val = 4'd0; op_val = 2'd0;
    alu_done = 1'b0; alu_err = 1'b0; alu_result = 16'h0;

    tv[0]  = mk(1, 0, 0, 0, 4'h1, 2'd0, 16'h0001, 16'h0000, 2'd0, ST_N1);
    tv[1]  = mk(1, 0, 0, 0, 4'h2, 2'd0, 16'h0012, 16'h0000, 2'd0, ST_N1);
    tv[2]  = mk(1, 0, 0, 0, 4'h3, 2'd0, 16'h0123, 16'h0000, 2'd0, ST_N1);
    tv[3]  = mk(0, 0, 1, 0, 4'h0, 2'd0, 16'h0123, 16'h0000, 2'd0, ST_N1);
    tv[4]  = mk(1, 0, 0, 0, 4'h4, 2'd0, 16'h1234, 16'h0000, 2'd0, ST_N1);
    tv[5]  = mk(1, 0, 0, 0, 4'h5, 2'd0, 16'h1234, 16'h0000, 2'd0, ST_N1);
    tv[6]  = mk(0, 0, 0, 0, 4'h9, 2'd3, 16'h1234, 16'h0000, 2'd0, ST_N1);
    tv[7]  = mk(0, 1, 0, 0, 4'h0, 2'd2, 16'h1234, 16'h0000, 2'd2, ST_OP);
    tv[8]  = mk(0, 1, 0, 0, 4'h0, 2'd1, 16'h1234, 16'h0000, 2'd1, ST_OP);
    tv[9]  = mk(0, 0, 1, 0, 4'h0, 2'd0, 16'h1234, 16'h0000, 2'd1, ST_OP);
    tv[10] = mk(1, 0, 0, 0, 4'h9, 2'd0, 16'h1234, 16'h0009, 2'd1, ST_N2);
    tv[11] = mk(1, 0, 0, 0, 4'h8, 2'd0, 16'h1234, 16'h0098, 2'd1, ST_N2);
    tv[12] = mk(1, 0, 0, 1, 4'h7, 2'd0, 16'h0000, 16'h0000, 2'd0, ST_N1);
    tv[13] = mk(1, 1, 0, 0, 4'h7, 2'd3, 16'h0000, 16'h0000, 2'd3, ST_OP);
    tv[14] = mk(1, 0, 0, 0, 4'h6, 2'd0, 16'h0000, 16'h0006, 2'd3, ST_N2);
    tv[15] = mk(0, 0, 0, 1, 4'h0, 2'd0, 16'h0000, 16'h0000, 2'd0, ST_N1);

    repeat (3) @(negedge clk);
    chk("reset_state", {alu_start, key_ready, error, num1, num2, operation, state},
                       {1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 3'(ST_N1)});
    reset = 1'b1;
    @(negedge clk);

    // table-driven entry sequence
    for (int i = 0; i < 16; i++) begin
      press(tv[i].n, tv[i].o, tv[i].e, tv[i].c, tv[i].nv, tv[i].ov);
      chk_st($sformatf("vec%0d", i), tv[i].e1, tv[i].e2, tv[i].eop, tv[i].est, 1'b0);
    end

    // 7 + 5 = with a 3-cycle ALU
    num(4'd7); op(OP_ADD); num(4'd5); eq();
    chk("b_exec", {alu_start, key_ready, state}, {1'b1, 1'b0, 3'(ST_EXEC)});
    run_alu("b_alu", 3, 16'd12, 1'b0);
    chk_st("b_res", 16'h000C, 16'h0000, OP_ADD, ST_RES, 1'b0);
    eq();
    chk_st("b_res_eq", 16'h000C, 16'h0000, OP_ADD, ST_RES, 1'b0);
    num(4'd4);
    chk_st("b_res_num", 16'h0004, 16'h0000, OP_ADD, ST_N1, 1'b0);

    // chained 1 + 2 + 3 =, then reuse result with a pending operator change
    clr();
    begin
      int base;
      base = starts;
      num(4'd1); op(OP_ADD); num(4'd2); op(OP_ADD);
      run_alu("c_alu1", 2, 16'd3, 1'b0);
      chk_st("c_chain1", 16'h0003, 16'h0000, OP_ADD, ST_OP, 1'b0);
      num(4'd3);
      chk_st("c_n2", 16'h0003, 16'h0003, OP_ADD, ST_N2, 1'b0);
      eq();
      run_alu("c_alu2", 2, 16'd6, 1'b0);
      chk_st("c_final", 16'h0006, 16'h0000, OP_ADD, ST_RES, 1'b0);
      chk("c_starts", 64'(starts - base), 64'd2);
    end
    op(OP_DIV);
    chk_st("c_res_op", 16'h0006, 16'h0000, OP_DIV, ST_OP, 1'b0);
    num(4'd2); op(OP_SUB);
    run_alu("c_alu3", 1, 16'h0012, 1'b0);
    chk_st("c_pend", 16'h0012, 16'h0000, OP_SUB, ST_OP, 1'b0);

    // ALU error path
    clr();
    num(4'd5); op(OP_DIV); num(4'd4); eq();
    run_alu("d_alu", 2, 16'h0000, 1'b1);
    chk_st("d_err", 16'h0005, 16'h0004, OP_DIV, ST_ERR, 1'b1);
    num(4'd7); op(OP_MUL); eq();
    chk_st("d_err_hold", 16'h0005, 16'h0004, OP_DIV, ST_ERR, 1'b1);
    clr();
    chk_st("d_clr", 16'h0000, 16'h0000, 2'd0, ST_N1, 1'b0);

    // stray alu_done outside EXEC
    num(4'd2);
    alu_done = 1'b1; alu_result = 16'hFFFF;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 16'h0;
    chk_st("e_stray_done", 16'h0002, 16'h0000, 2'd0, ST_N1, 1'b0);

    // reset during EXEC, late alu_done
    clr();
    num(4'd8); op(OP_ADD); num(4'd1); eq();
    chk("f_exec", 64'(state), 64'(ST_EXEC));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    alu_done = 1'b1; alu_result = 16'h0009;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 16'h0;
    @(negedge clk);
    chk_st("f_abort", 16'h0000, 16'h0000, 2'd0, ST_N1, 1'b0);
    chk("f_nostart", 64'(alu_start), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
